// File: rtl/md_pkg.sv
// Shared encodings, widths and result payload for the multiply/divide unit.
package md_pkg;

   localparam int unsigned DW       = 32;
   localparam int unsigned MD_ITERS = 32;
   localparam int unsigned CNT_W    = $clog2(MD_ITERS);

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } md_state_e;

   typedef struct packed {
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
   } md_res_t;

   // Iterative ops are exactly the encodings with bit 2 clear.
   function automatic logic is_arith(input logic [2:0] op);
      return !op[2];
   endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage request/response bundle between the pipeline and the MD unit.
interface md_if import md_pkg::*;;
   logic          start;
   logic [2:0]    md_op;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic          cancel;
   logic          busy;
   logic          done;
   logic [DW-1:0] hi;
   logic [DW-1:0] lo;

   modport master (output start, md_op, rs_data, rt_data, cancel,
                   input  busy, done, hi, lo);
   modport slave  (input  start, md_op, rs_data, rt_data, cancel,
                   output busy, done, hi, lo);
endinterface

// File: rtl/md_iter_dp.sv
// Magnitude/sign capture plus a 64-bit shift register doing one
// shift-add (multiply) or restoring-subtract (divide) step per cycle.
module md_iter_dp import md_pkg::*; (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic          commit,
   input  logic [2:0]    op,
   input  logic [DW-1:0] rs,
   input  logic [DW-1:0] rt,
   output md_res_t       res_c
);
   localparam int unsigned AW = 2 * DW;

   logic [AW-1:0] acc_q, acc_d, step_val, prod;
   logic [DW-1:0] opnd_q, opnd_d, src_q, src_d;
   logic          is_div_q, is_div_d, neg_lo_q, neg_lo_d;
   logic          neg_hi_q, neg_hi_d, div0_q, div0_d;
   logic          signed_op, rs_neg, rt_neg;
   logic [DW-1:0] rs_mag, rt_mag, quo, rem;
   logic [DW:0]   madd, trial;
   logic [AW:0]   dsh;

   always_comb begin
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      rs_neg    = signed_op & rs[DW-1];
      rt_neg    = signed_op & rt[DW-1];
      rs_mag    = rs_neg ? DW'(0) - rs : rs;
      rt_mag    = rt_neg ? DW'(0) - rt : rt;
   end

   // One iteration: multiply consumes multiplier bits LSB-first, divide
   // shifts the dividend into the remainder half and tries a subtract.
   always_comb begin
      madd  = {1'b0, acc_q[AW-1:DW]} + {1'b0, (acc_q[0] ? opnd_q : DW'(0))};
      dsh   = {acc_q, 1'b0};
      trial = dsh[AW:DW] - {1'b0, opnd_q};
      if (is_div_q) begin
         step_val = trial[DW] ? dsh[AW-1:0] : {trial[DW-1:0], dsh[DW-1:1], 1'b1};
      end else begin
         step_val = {madd, acc_q[DW-1:1]};
      end
   end

   // Sign fix-up is applied to the value produced by the final step.
   always_comb begin
      prod     = neg_lo_q ? AW'(0) - step_val : step_val;
      quo      = neg_lo_q ? DW'(0) - step_val[DW-1:0] : step_val[DW-1:0];
      rem      = neg_hi_q ? DW'(0) - step_val[AW-1:DW] : step_val[AW-1:DW];
      res_c.hi = prod[AW-1:DW];
      res_c.lo = prod[DW-1:0];
      if (is_div_q) begin
         if (div0_q) begin
            res_c.hi = src_q;
            res_c.lo = '1;
         end else begin
            res_c.hi = rem;
            res_c.lo = quo;
         end
      end
   end

   always_comb begin
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      src_d    = src_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      div0_d   = div0_q;
      if (load) begin
         acc_d    = {DW'(0), (op[1] ? rs_mag : rt_mag)};
         opnd_d   = op[1] ? rt_mag : rs_mag;
         src_d    = rs;
         is_div_d = op[1];
         neg_lo_d = rs_neg ^ rt_neg;
         neg_hi_d = op[1] ? rs_neg : (rs_neg ^ rt_neg);
         div0_d   = op[1] && (rt == DW'(0));
      end else if (commit) begin
         acc_d = '0;
      end else if (step) begin
         acc_d = step_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         src_q    <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         src_q    <= src_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         div0_q   <= div0_d;
      end
   end

endmodule

// File: rtl/md_unit.sv
// MIPS multiply/divide unit: sequencing FSM, iteration counter and the
// architectural HI/LO registers around the iterative datapath.
module md_unit import md_pkg::*; (
   input logic clk,
   input logic rst,
   md_if.slave bus
);
   md_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic           busy_q, busy_d, done_q, done_d;
   logic           accept_c, last_c, load_c, step_c, commit_c;
   md_res_t        res_c;

   assign accept_c = bus.start && !bus.cancel && (state_q == IDLE);
   assign last_c   = (cnt_q == CNT_W'(MD_ITERS - 1));

   md_iter_dp u_dp (
      .clk    (clk),
      .rst    (rst),
      .load   (load_c),
      .step   (step_c),
      .commit (commit_c),
      .op     (bus.md_op),
      .rs     (bus.rs_data),
      .rt     (bus.rt_data),
      .res_c  (res_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept_c && is_arith(bus.md_op)) state_d = CALC;
         CALC: begin
            if (bus.cancel)  state_d = IDLE;
            else if (last_c) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Cancel beats the final step, so an aborted op never commits.
   always_comb begin
      load_c   = accept_c && is_arith(bus.md_op);
      step_c   = (state_q == CALC) && !bus.cancel;
      commit_c = step_c && last_c;
      cnt_d    = '0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      if (step_c && !last_c) cnt_d = cnt_q + CNT_W'(1);
      if (accept_c && (bus.md_op == MD_MTHI)) hi_d = bus.rs_data;
      if (accept_c && (bus.md_op == MD_MTLO)) lo_d = bus.rs_data;
      if (commit_c) begin
         hi_d = res_c.hi;
         lo_d = res_c.lo;
      end
      busy_d = (state_d == CALC);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, randomized ops against a
// plain-arithmetic reference, and hand-written cancel/reset sequences.
module tb_md_unit;
   import md_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   md_if bus ();
   md_unit dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: 64-bit host arithmetic, division truncates toward zero.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt);
      longint a, b, q, r;
      logic [63:0] ua, ub, uq, ur;
      a  = longint'($signed(rs));
      b  = longint'($signed(rt));
      ua = {32'd0, rs};
      ub = {32'd0, rt};
      case (op)
         3'b000: return 64'(a * b);
         3'b001: return ua * ub;
         3'b010: begin
            if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
            q = a / b;
            r = a % b;
            return {r[31:0], q[31:0]};
         end
         3'b011: begin
            if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic run_arith(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = op; bus.rs_data = rs; bus.rt_data = rt;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check({name, " busy_cycles"}, 64'(cyc), 64'd32);
      check({name, " done"}, 64'(bus.done), 64'd1);
      check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
      check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
      @(negedge clk);
      check({name, " done_one_cycle"}, 64'(bus.done), 64'd0);
      model_hi = exp_hi;
      model_lo = exp_lo;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      logic [63:0] exp;
      logic [2:0]  op;
      logic [31:0] rs, rt;
      int          sel, seen, cyc;

      vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg"};
      vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
      vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"};
      vecs[3] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7_2"};
      vecs[4] = '{MD_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by0"};
      vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
      vecs[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0_neg"};

      rst = 1'b1;
      bus.start = 1'b0; bus.md_op = 3'b000; bus.rs_data = '0; bus.rt_data = '0; bus.cancel = 1'b0;
      #3;
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset hi", 64'(bus.hi), 64'd0);
      check("reset lo", 64'(bus.lo), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_arith(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].name);

      for (int i = 0; i < 40; i++) begin
         op  = 3'($urandom_range(0, 3));
         rs  = $urandom;
         rt  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0)      rt = 32'd0;
         else if (sel == 1) rt = 32'($urandom_range(1, 15));
         else if (sel == 2) rs = 32'h8000_0000;
         exp = ref_md(op, rs, rt);
         run_arith(op, rs, rt, exp[63:32], exp[31:0], $sformatf("rand%0d", i));
      end

      // mthi in IDLE is a single-cycle write with no busy/done
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = MD_MTHI; bus.rs_data = 32'h1234;
      @(negedge clk);
      bus.start = 1'b0;
      check("mthi hi", 64'(bus.hi), 64'h1234);
      check("mthi busy", 64'(bus.busy), 64'd0);
      check("mthi done", 64'(bus.done), 64'd0);
      model_hi = 32'h1234;

      // mult with an ignored mtlo mid-flight, then cancelled
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = MD_MULT; bus.rs_data = 32'd7; bus.rt_data = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int c = 1; c < 10; c++) begin
         if (c == 5) begin
            check("cancel busy_mid", 64'(bus.busy), 64'd1);
            bus.start = 1'b1; bus.md_op = MD_MTLO; bus.rs_data = 32'hDEAD;
         end
         if (c == 6) bus.start = 1'b0;
         if (bus.done) seen++;
         @(negedge clk);
      end
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      check("cancel busy", 64'(bus.busy), 64'd0);
      check("cancel hi", 64'(bus.hi), 64'(model_hi));
      check("cancel lo", 64'(bus.lo), 64'(model_lo));
      for (int c = 0; c < 4; c++) begin
         if (bus.done) seen++;
         @(negedge clk);
      end
      check("cancel no_done", 64'(seen), 64'd0);

      // start in DONE is ignored
      bus.start = 1'b1; bus.md_op = MD_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check("done_start latency", 64'(cyc), 64'd32);
      check("done_start hi", 64'(bus.hi), 64'd2);
      check("done_start lo", 64'(bus.lo), 64'd14);
      bus.start = 1'b1; bus.md_op = MD_MTHI; bus.rs_data = 32'hBEEF;
      @(negedge clk);
      bus.start = 1'b0;
      check("done_start ignored hi", 64'(bus.hi), 64'd2);
      check("done_start busy", 64'(bus.busy), 64'd0);
      model_hi = 32'd2; model_lo = 32'd14;

      // cancel in IDLE wins over start; reserved ops do nothing
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = MD_MTHI; bus.rs_data = 32'h5555; bus.cancel = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      check("idle_cancel hi", 64'(bus.hi), 64'(model_hi));
      bus.start = 1'b1; bus.md_op = 3'b110; bus.rs_data = 32'h6666;
      @(negedge clk);
      bus.md_op = 3'b111;
      @(negedge clk);
      bus.start = 1'b0;
      check("reserved busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("reserved hi", 64'(bus.hi), 64'(model_hi));
      check("reserved lo", 64'(bus.lo), 64'(model_lo));

      // async reset mid-CALC at counter 17
      bus.start = 1'b1; bus.md_op = MD_MULTU; bus.rs_data = 32'hFFFF_0000; bus.rt_data = 32'h1234_5678;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_rst busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst busy", 64'(bus.busy), 64'd0);
      check("async_rst hi", 64'(bus.hi), 64'd0);
      check("async_rst lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_arith(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Executes mult, multu, div and divu over 32 cycles, and executes mthi and mtlo in a single cycle.
- Sits beside the ALU in EX and is sequenced by its own FSM.
- The pipeline stalls on busy and aborts an operation with cancel on an exception or flush.

Parameters:
- DW, 32, operand/result width; 32 is the only supported value.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request strobe from EX; sampled on each rising edge
- md_op  in  3  op select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
- rs_data  in  32  multiplicand/dividend; source for mthi/mtlo
- rt_data  in  32  multiplier/divisor
- cancel  in  1  abort the in-flight op (exception/flush)
- busy  out  1  iterative op in progress; pipeline must stall any MD instruction
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal shift regs=0. Takes effect immediately, including mid-CALC.
- States and transitions:
  - IDLE, start & md_op in {000..011} & !cancel: latch operands, go to CALC, counter=0.
  - IDLE, start & md_op=100 & !cancel: hi<=rs_data on that edge; stay in IDLE; no busy, no done.
  - IDLE, start & md_op=101 & !cancel: lo<=rs_data on that edge; stay in IDLE; no busy, no done.
  - IDLE, reserved md_op: ignored.
  - CALC: one iteration per cycle, counter++. At the edge where counter==31, write final HI/LO and go to DONE.
  - CALC & cancel: go to IDLE at the next edge; HI/LO unchanged; no done.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally. A start sampled in DONE is ignored.
- Latency:
  - start accepted at edge E0.
  - busy=1 for 32 cycles (E0..E32).
  - HI/LO updated at E32.
  - done=1 in the cycle after E32.
- busy is registered: busy = (state==CALC).
- start while busy (or in DONE) is ignored, including mthi/mtlo; the pipeline guarantees a stall.
- cancel in IDLE: start in the same cycle is ignored (cancel wins).
- cancel in DONE: no effect; the result is already committed.
- Multiply:
  - Signed ops use magnitudes |rs|,|rt|; 32 shift-add iterations on a 64-bit product.
  - If the signs differ, the product is negated (two's complement of the 64-bit product) at commit.
  - HI=product[63:32], LO=product[31:0].
- Divide (restoring, one quotient bit per cycle on magnitudes):
  - Quotient truncates toward zero; remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - Divisor 0, any div op: LO=0xFFFFFFFF, HI=rs_data; full 32-cycle latency.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no exception.
- All arithmetic is at 32/64-bit width with no saturation; the unit raises no overflow flag.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - FSM state encoding: IDLE, CALC, DONE.
  - Iteration count constant MD_ITERS=32.
- Sub-module md_iter_dp owns the datapath:
  - Operand magnitude/sign capture, 64-bit product/remainder shift register and the one-step add/subtract, controlled by load/step/commit strobes.
- md_unit keeps the FSM, counter, HI/LO registers and done/busy.

Test Plan:
- mult rs=0xFFFFFFFE, rt=0x00000003 -> busy high 32 cycles, then done pulse with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu rs=7, rt=2 -> LO=3, HI=1.
- divu rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5 after 32 cycles; div rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- In IDLE, mthi rs=0x1234 -> hi=0x1234 next cycle, busy/done stay 0. Then mult, with a second start (mtlo) at cycle 5 ignored and cancel at cycle 10 -> busy=0 next cycle, no done, HI=0x1234, LO unchanged.
- Async rst asserted mid-CALC (counter=17) between clock edges -> busy=0, hi=lo=0 immediately. After release, a fresh multu 3x4 gives LO=12, HI=0.
